// File: rtl/csa_pkg.sv
// Shared constants and the per-stage pipeline record for the pipelined carry-select adder.
package csa_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;
    // Widest operand the stage record can carry; wider configurations are rejected at elaboration.
    localparam int MAX_WIDTH  = 64;

    // One pipeline stage: operands travel whole (b already in effective form) and the
    // partial sum fills in one segment per stage at its final bit position.
    typedef struct packed {
        logic                 valid;
        logic                 sub;
        logic                 carry;
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
        logic [MAX_WIDTH-1:0] sum;
    } stage_t;

    // Signed overflow: both addends share a sign that the result does not.
    function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/pipelined_carry_select_adder_if.sv
// Operand/result bus of the pipelined carry-select adder.
interface pipelined_carry_select_adder_if
    import csa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    // Valid/ready: a beat moves on a rising edge where valid && ready; the source holds its
    // payload stable while valid && !ready, and ready never depends combinationally on valid.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/csa_segment.sv
// One carry-select segment: two ripple adders (carry-in 0 and 1) and a select mux.
module csa_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum_seg,
    output logic           carry_out
);

    logic [SEG:0]   c0;
    logic [SEG:0]   c1;
    logic [SEG-1:0] s0;
    logic [SEG-1:0] s1;

    always_comb begin
        c0    = '0;
        c1    = '0;
        s0    = '0;
        s1    = '0;
        c1[0] = 1'b1;
        for (int i = 0; i < SEG; i++) begin
            s0[i]   = a[i] ^ b[i] ^ c0[i];
            c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
            s1[i]   = a[i] ^ b[i] ^ c1[i];
            c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
        end
    end

    assign sum_seg   = cin ? s1 : s0;
    assign carry_out = cin ? c1[SEG] : c0[SEG];

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// Add/subtract pipeline: one carry-select segment per stage, skewed operands in, deskewed sum out.
module pipelined_carry_select_adder
    import csa_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic                           clk,
    input  logic                           rst_n,
    pipelined_carry_select_adder_if.slave  bus
);

    localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;
    localparam int SEG         = WIDTH / SAFE_STAGES;

    if ((STAGES < 1) || ((WIDTH % SAFE_STAGES) != 0) || (WIDTH > MAX_WIDTH)) begin : g_bad_cfg
        $fatal(1, "pipelined_carry_select_adder: WIDTH must be a multiple of STAGES >= 1 and fit MAX_WIDTH");
    end

    stage_t           pipe     [SAFE_STAGES];
    stage_t           nxt      [SAFE_STAGES];
    logic [SEG-1:0]   seg_a    [SAFE_STAGES];
    logic [SEG-1:0]   seg_b    [SAFE_STAGES];
    logic [SEG-1:0]   seg_sum  [SAFE_STAGES];
    logic             seg_cin  [SAFE_STAGES];
    logic             seg_cout [SAFE_STAGES];
    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // The whole pipe advances together; it only stalls when a finished result is refused.
    assign en           = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = en;

    // Subtraction is a + ~b + !cin, so the carry out reads as "no borrow".
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.sub ? !bus.cin : bus.cin;

    always_comb begin
        seg_a[0]   = bus.a[SEG-1:0];
        seg_b[0]   = b_eff[SEG-1:0];
        seg_cin[0] = cin_eff;
        for (int k = 1; k < SAFE_STAGES; k++) begin
            seg_a[k]   = pipe[k-1].a[k*SEG +: SEG];
            seg_b[k]   = pipe[k-1].b[k*SEG +: SEG];
            seg_cin[k] = pipe[k-1].carry;
        end
    end

    for (genvar k = 0; k < SAFE_STAGES; k++) begin : g_seg
        csa_segment #(
            .SEG (SEG)
        ) u_segment (
            .a         (seg_a[k]),
            .b         (seg_b[k]),
            .cin       (seg_cin[k]),
            .sum_seg   (seg_sum[k]),
            .carry_out (seg_cout[k])
        );
    end

    always_comb begin
        nxt[0]                = '0;
        nxt[0].valid          = bus.in_valid;
        nxt[0].sub            = bus.sub;
        nxt[0].a              = MAX_WIDTH'(bus.a);
        nxt[0].b              = MAX_WIDTH'(b_eff);
        nxt[0].sum[SEG-1:0]   = seg_sum[0];
        nxt[0].carry          = seg_cout[0];
        for (int k = 1; k < SAFE_STAGES; k++) begin
            nxt[k]                   = pipe[k-1];
            nxt[k].sum[k*SEG +: SEG] = seg_sum[k];
            nxt[k].carry             = seg_cout[k];
        end
    end

    // Data only loads behind a valid beat, so bubbles leave the last real result (or the
    // reset zeros) on the outputs instead of garbage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SAFE_STAGES; k++) begin
                pipe[k] <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < SAFE_STAGES; k++) begin
                if (nxt[k].valid) begin
                    pipe[k] <= nxt[k];
                end else begin
                    pipe[k].valid <= 1'b0;
                end
            end
        end
    end

    assign bus.out_valid = pipe[SAFE_STAGES-1].valid;
    assign bus.sum       = pipe[SAFE_STAGES-1].sum[WIDTH-1:0];
    assign bus.cout      = pipe[SAFE_STAGES-1].carry;
    assign bus.ovf       = ovf_flag(pipe[SAFE_STAGES-1].a[WIDTH-1],
                                    pipe[SAFE_STAGES-1].b[WIDTH-1],
                                    pipe[SAFE_STAGES-1].sum[WIDTH-1]);

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Bench for the pipelined carry-select adder: directed cases on the default build, then
// randomized traffic on nine WIDTH/STAGES builds against an arithmetic reference model.
module tb_pipelined_carry_select_adder;

    localparam int MAIN_STAGES = 4;
    localparam int N_RAND      = 1112;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rand_go = 1'b0;
    int   n_vec    = 0;
    int   n_miss   = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic; result packed as {ovf, cout, sum[w-1:0]}.
    function automatic logic [63:0] ref_result(input int w, input logic [31:0] a,
                                               input logic [31:0] b, input logic cin,
                                               input logic sub);
        longint span, half, ua, ub, c, full, sa, sb, tru;
        logic   co, ov;
        span = longint'(1) << w;
        half = span >> 1;
        ua   = longint'(a) & (span - 1);
        ub   = longint'(b) & (span - 1);
        c    = longint'(cin);
        if (!sub) begin
            full = ua + ub + c;
            co   = (full >= span);
        end else begin
            full = ua - ub - c;
            co   = (full >= 0);
        end
        sa  = (ua >= half) ? ua - span : ua;
        sb  = (ub >= half) ? ub - span : ub;
        tru = sub ? (sa - sb - c) : (sa + sb + c);
        ov  = (tru >= half) || (tru < -half);
        return (64'(ov) << (w + 1)) | (64'(co) << w) | (64'(full) & 64'(span - 1));
    endfunction

    function automatic logic [31:0] rand_operand(input int w);
        logic [63:0] mask;
        logic [63:0] v;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 7))
            0:       v = 64'd0;
            1:       v = mask;
            2:       v = 64'd1 << (w - 1);
            3:       v = (64'd1 << (w - 1)) - 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        return 32'(v & mask);
    endfunction

    // ---------------- default build: directed checks ----------------
    pipelined_carry_select_adder_if #(.WIDTH(16)) dbus();

    pipelined_carry_select_adder u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dbus)
    );

    logic [63:0] exp_q[$];
    int          n_out_m = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (dbus.in_valid && dbus.in_ready)
                exp_q.push_back(ref_result(16, 32'(dbus.a), 32'(dbus.b), dbus.cin, dbus.sub));
            if (dbus.out_valid && dbus.out_ready) begin
                n_out_m++;
                if (exp_q.size() == 0) check("main_extra_result", 64'd1, 64'd0);
                else check("main_result", 64'({dbus.ovf, dbus.cout, dbus.sum}), exp_q.pop_front());
            end
        end
    end

    task automatic send_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input logic sub);
        int g;
        g = 0;
        dbus.a = a;
        dbus.b = b;
        dbus.cin = cin;
        dbus.sub = sub;
        dbus.in_valid = 1'b1;
        while (!dbus.in_ready && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 100) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        dbus.in_valid = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic [15:0] es,
                         input logic ec, input logic eo);
        int lat;
        dbus.out_ready = 1'b1;
        send_op(a, b, cin, sub);
        lat = 0;
        while (!dbus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(MAIN_STAGES - 1));
        check({tag, "_sum"}, 64'(dbus.sum), 64'(es));
        check({tag, "_cout"}, 64'(dbus.cout), 64'(ec));
        check({tag, "_ovf"}, 64'(dbus.ovf), 64'(eo));
        @(posedge clk); #1;
    endtask

    // ---------------- randomized builds: WIDTH {8,16,32} x STAGES {1,2,4} ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_w
        for (genvar gj = 0; gj < 3; gj++) begin : g_s
            localparam int W = 8 << gi;
            localparam int S = 1 << gj;

            pipelined_carry_select_adder_if #(.WIDTH(W)) rbus();

            pipelined_carry_select_adder #(
                .WIDTH  (W),
                .STAGES (S)
            ) u_dut (
                .clk   (clk),
                .rst_n (rst_n),
                .bus   (rbus)
            );

            logic [63:0] q[$];
            int          n_in  = 0;
            int          n_out = 0;
            logic        took  = 1'b0;

            always @(negedge clk) begin
                took = 1'b0;
                if (rst_n) begin
                    if (rbus.in_valid && rbus.in_ready) begin
                        q.push_back(ref_result(W, 32'(rbus.a), 32'(rbus.b), rbus.cin, rbus.sub));
                        n_in++;
                        took = 1'b1;
                    end
                    if (rbus.out_valid && rbus.out_ready) begin
                        n_out++;
                        if (q.size() == 0)
                            check($sformatf("w%0d_s%0d_extra", W, S), 64'd1, 64'd0);
                        else
                            check($sformatf("w%0d_s%0d_result", W, S),
                                  64'({rbus.ovf, rbus.cout, rbus.sum}), q.pop_front());
                    end
                end
            end

            initial begin
                int cyc;
                rbus.in_valid  = 1'b0;
                rbus.a         = '0;
                rbus.b         = '0;
                rbus.cin       = 1'b0;
                rbus.sub       = 1'b0;
                rbus.out_ready = 1'b0;
                wait (rand_go);
                cyc = 0;
                while (n_in < N_RAND && cyc < 20000) begin
                    @(posedge clk); #1;
                    cyc++;
                    if (!rbus.in_valid || took) begin
                        rbus.in_valid = ($urandom_range(0, 3) != 0);
                        rbus.a        = W'(rand_operand(W));
                        rbus.b        = W'(rand_operand(W));
                        rbus.cin      = 1'($urandom_range(0, 1));
                        rbus.sub      = 1'($urandom_range(0, 1));
                    end
                    rbus.out_ready = ($urandom_range(0, 3) != 0);
                end
                rbus.in_valid  = 1'b0;
                rbus.out_ready = 1'b1;
                check($sformatf("w%0d_s%0d_count_in", W, S), 64'(n_in), 64'(N_RAND));
                cyc = 0;
                while (n_out < n_in && cyc < 200) begin
                    @(posedge clk); #1;
                    cyc++;
                end
                check($sformatf("w%0d_s%0d_count_out", W, S), 64'(n_out), 64'(n_in));
                done_cnt++;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] bp_a [6];
        logic [15:0] bp_b [6];
        logic        bp_c [6];
        logic        bp_s [6];
        logic [63:0] bp_first;
        int          g;
        int          base;
        int          stale;

        dbus.in_valid  = 1'b0;
        dbus.a         = '0;
        dbus.b         = '0;
        dbus.cin       = 1'b0;
        dbus.sub       = 1'b0;
        dbus.out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", 64'(dbus.out_valid), 64'd0);
        check("rst_sum", 64'(dbus.sum), 64'd0);
        check("rst_cout", 64'(dbus.cout), 64'd0);
        check("rst_ovf", 64'(dbus.ovf), 64'd0);
        check("rst_in_ready", 64'(dbus.in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("post_rst_in_ready", 64'(dbus.in_ready), 64'd1);

        // Directed arithmetic
        do_op("add_2_2_1", 16'd2, 16'd2, 1'b1, 1'b0, 16'd5, 1'b0, 1'b0);
        do_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("sub_5_7_0", 16'd5, 16'd7, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_100_0_1", 16'd100, 16'd0, 1'b1, 1'b1, 16'd99, 1'b1, 1'b0);

        // Backpressure: six back-to-back ops against a stalled consumer
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = 16'($urandom);
            bp_b[i] = 16'($urandom);
            bp_c[i] = 1'($urandom_range(0, 1));
            bp_s[i] = 1'($urandom_range(0, 1));
        end
        bp_first = ref_result(16, 32'(bp_a[0]), 32'(bp_b[0]), bp_c[0], bp_s[0]);
        dbus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_op(bp_a[i], bp_b[i], bp_c[i], bp_s[i]);
            end
            begin
                g = 0;
                while (!dbus.out_valid && g < 50) begin
                    @(posedge clk); #1;
                    g++;
                end
                check("bp_first_valid", 64'(dbus.out_valid), 64'd1);
                check("bp_in_ready_drop", 64'(dbus.in_ready), 64'd0);
                check("bp_first_value", 64'({dbus.ovf, dbus.cout, dbus.sum}), bp_first);
                for (int i = 0; i < 5; i++) begin
                    @(posedge clk); #1;
                    check("bp_hold", 64'({dbus.ovf, dbus.cout, dbus.sum}), bp_first);
                    check("bp_hold_ready", 64'(dbus.in_ready), 64'd0);
                end
                base = n_out_m;
                dbus.out_ready = 1'b1;
                g = 0;
                while ((n_out_m - base) < 6 && g < 60) begin
                    @(posedge clk); #1;
                    g++;
                end
                check("bp_count", 64'(n_out_m - base), 64'd6);
            end
        join
        @(posedge clk); #1;
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset with three ops in flight
        dbus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_op(16'($urandom), 16'($urandom), 1'b0, 1'b0);
        g = 0;
        while (!dbus.out_valid && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(dbus.out_valid), 64'd0);
        check("midrst_sum", 64'(dbus.sum), 64'd0);
        check("midrst_in_ready", 64'(dbus.in_ready), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dbus.out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (dbus.out_valid) stale++;
        end
        check("midrst_stale", 64'(stale), 64'd0);
        do_op("fresh_12_3_1", 16'd12, 16'd3, 1'b1, 1'b0, 16'd16, 1'b0, 1'b0);

        // Randomized traffic on all builds
        rand_go = 1'b1;
        g = 0;
        while (done_cnt < 9 && g < 60000) begin
            @(posedge clk);
            g++;
        end
        check("rand_all_done", 64'(done_cnt), 64'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipelined_carry_select_adder.md
PIPELINED_CARRY_SELECT_ADDER -- requirements
Module: pipelined_carry_select_adder

Interface
REQ-001 WIDTH, 16, operand/sum width in bits.
REQ-002 STAGES, 4, number of pipeline stages; each stage is one carry-select segment of SEG = WIDTH/STAGES bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand set on a, b, cin, sub is valid.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in (add) / borrow-in (subtract).
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  sum, cout, ovf hold a valid result.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry-out (add) / not-borrow (subtract).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Add: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-017 Subtract: {cout,sum} = a + ~b + !cin, i.e. a - b - cin; cout=1 means no borrow.
REQ-018 ovf = 1 when the sign bits of a and effective b agree and differ from the sign bit of sum.
REQ-019 Stage k (0..STAGES-1) computes bits [k*SEG +: SEG] both for carry 0 and carry 1, then selects with the carry registered from stage k-1 (stage 0 uses the effective carry-in).
REQ-020 Operand bits for later segments are carried forward in skew registers; completed sum bits are carried forward in deskew registers, so all bits of one result leave together.
REQ-021 Latency: a transaction accepted at edge N appears on outputs after edge N+STAGES-1, when there is no stall.
REQ-022 Throughput: one transaction per cycle with no stall.
REQ-023 Global advance enable en = !(out_valid && !out_ready); in_ready = en.
REQ-024 Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-025 When en=0, every stage register (data and valid) holds its value; sum/cout/ovf are stable while out_valid && !out_ready.
REQ-026 in_valid=0 on an accepted cycle injects a bubble (stage valid 0); bubbles never assert out_valid.
REQ-027 Result order equals acceptance order; no transaction is dropped or duplicated.
REQ-028 Data registers of invalid stages are don't-care, but the outputs shall show 0 from reset until the first valid result.
REQ-029 WIDTH % STAGES != 0 or STAGES < 1 is illegal; elaboration shall fail.
REQ-030 STAGES = 1 degenerates to a single registered carry-select adder with latency 1.

Reset
REQ-031 rst_n low asynchronously clears all stage valid bits, carries and data registers: out_valid=0, sum=0, cout=0, ovf=0.
REQ-032 Reset mid-operation discards all in-flight transactions; no result from before reset emerges afterwards.
REQ-033 in_ready = 1 during and right after reset (pipeline empty).

Structure
REQ-034 Shared package csa_pkg holds the default WIDTH/STAGES constants and the stage record typedef (valid, skewed a/b, partial sum, carry, sub flag).
REQ-035 One sub-module csa_segment, parametrised by SEG: combinational dual ripple adder plus select mux, with outputs sum_seg and carry_out; instantiated STAGES times via generate.

Verification
REQ-036 Defaults, a=2, b=2, cin=1, sub=0 -> sum=5, cout=0, ovf=0, out_valid exactly 3 edges after acceptance.
REQ-037 a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0; a=16'h7FFF, b=1, cin=0 -> sum=16'h8000, ovf=1.
REQ-038 sub=1, a=5, b=7, cin=0 -> sum=16'hFFFE, cout=0; sub=1, a=100, b=0, cin=1 -> sum=99, cout=1.
REQ-039 Backpressure: stream 6 back-to-back ops with out_ready=0 -> in_ready drops once out_valid=1, the first result is held stable; on releasing out_ready, all 6 results emerge in order.
REQ-040 Assert rst_n low with 3 ops in flight -> out_valid=0 immediately; after release, no stale result appears; a fresh op 12+3+1 yields 16.
REQ-041 Random: 10k ops with random valid/ready, WIDTH in {8,16,32} and STAGES in {1,2,4} -> compare every result against a reference model; the count out equals the count in.
